// File: rtl/pong_input_cond.sv
// Input conditioner for the pong game logic: synchronises and debounces four active-low buttons.
// Optional macro CPU_PLAYER2_EN replaces player 2's outputs with a ball-tracking FSM.
module pong_input_cond #(
    parameter int DEBOUNCE_CYCLES  = 250_000,
    parameter int CNT_W            = 18,
    parameter int CPU_REACT_CYCLES = 1_000_000,
    parameter int CPU_DEADBAND     = 8,
    parameter int SQ_WIDTH         = 16,
    parameter int PDL_HEIGHT       = 96
) (
    input  logic       clk_0,
    input  logic       rst,
    input  logic       btn_up_p1_n,
    input  logic       btn_dn_p1_n,
    input  logic       btn_up_p2_n,
    input  logic       btn_dn_p2_n,
    input  logic [9:0] sq_ypos,
    input  logic [9:0] pdl2_ypos,
    output logic       up_p1,
    output logic       down_p1,
    output logic       up_p2,
    output logic       down_p2,
    output logic       any_press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Bit order everywhere: {dn_p2, up_p2, dn_p1, up_p1}
    logic [3:0]       raw_n;
    logic [3:0]       sync_a;
    logic [3:0]       sync_b;
    logic [3:0]       stable;
    logic [3:0]       stable_q;
    logic [CNT_W-1:0] cnt [4];

    assign raw_n = {btn_dn_p2_n, btn_up_p2_n, btn_dn_p1_n, btn_up_p1_n};

    always_ff @(posedge clk_0 or posedge rst) begin
        if (rst) begin
            sync_a <= '1;
            sync_b <= '1;
        end else begin
            sync_a <= raw_n;
            sync_b <= sync_a;
        end
    end

    // A level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk_0 or posedge rst) begin
        if (rst) begin
            stable <= '1;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync_b[i] != stable[i]) begin
                    if (cnt[i] == CNT_LAST) begin
                        stable[i] <= sync_b[i];
                        cnt[i]    <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk_0 or posedge rst) begin
        if (rst) begin
            stable_q  <= '1;
            any_press <= 1'b0;
        end else begin
            stable_q  <= stable;
            any_press <= |(stable_q & ~stable);
        end
    end

    assign up_p1   = stable_q[0];
    assign down_p1 = stable_q[1];

`ifdef CPU_PLAYER2_EN
    localparam logic [1:0] CPU_HOLD = 2'd0;
    localparam logic [1:0] CPU_UP   = 2'd1;
    localparam logic [1:0] CPU_DOWN = 2'd2;
    localparam int REACT_W = (CPU_REACT_CYCLES > 1) ? $clog2(CPU_REACT_CYCLES) : 1;
    localparam logic [REACT_W-1:0] REACT_LAST = REACT_W'(CPU_REACT_CYCLES - 1);

    logic [REACT_W-1:0] react_cnt;
    logic [1:0]         cpu_state;
    logic [1:0]         cpu_next;
    logic [10:0]        ball_c;
    logic [10:0]        pdl_c;

    assign ball_c = {1'b0, sq_ypos} + 11'(SQ_WIDTH / 2);
    assign pdl_c  = {1'b0, pdl2_ypos} + 11'(PDL_HEIGHT / 2);

    always_comb begin
        cpu_next = CPU_HOLD;
        if (ball_c + 11'(CPU_DEADBAND) < pdl_c) begin
            cpu_next = CPU_UP;
        end else if (ball_c > pdl_c + 11'(CPU_DEADBAND)) begin
            cpu_next = CPU_DOWN;
        end
    end

    // The CPU only reconsiders its move once per reaction interval
    always_ff @(posedge clk_0 or posedge rst) begin
        if (rst) begin
            react_cnt <= '0;
            cpu_state <= CPU_HOLD;
        end else if (react_cnt == REACT_LAST) begin
            react_cnt <= '0;
            cpu_state <= cpu_next;
        end else begin
            react_cnt <= react_cnt + REACT_W'(1);
        end
    end

    assign up_p2   = (cpu_state != CPU_UP);
    assign down_p2 = (cpu_state != CPU_DOWN);
`else
    localparam int unused_cpu_params = CPU_REACT_CYCLES + CPU_DEADBAND + SQ_WIDTH + PDL_HEIGHT;
    logic unused_cpu_inputs;

    assign unused_cpu_inputs = &{1'b0, sq_ypos, pdl2_ypos};
    assign up_p2   = stable_q[2];
    assign down_p2 = stable_q[3];
`endif

endmodule

// File: tb/tb_pong_input_cond.sv
// Self-checking bench for pong_input_cond: directed cases plus random button activity
// checked against a sample-window reference model.
module tb_pong_input_cond;

    localparam int DEB   = 8;
    localparam int REACT = 4;

    logic       clk_0 = 1'b0;
    logic       rst;
    logic       btn_up_p1_n, btn_dn_p1_n, btn_up_p2_n, btn_dn_p2_n;
    logic [9:0] sq_ypos, pdl2_ypos;
    logic       up_p1, down_p1, up_p2, down_p2, any_press;

    always #5 clk_0 = ~clk_0;

    pong_input_cond #(
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (4),
        .CPU_REACT_CYCLES(REACT),
        .CPU_DEADBAND    (8),
        .SQ_WIDTH        (16),
        .PDL_HEIGHT      (96)
    ) dut (
        .clk_0      (clk_0),
        .rst        (rst),
        .btn_up_p1_n(btn_up_p1_n),
        .btn_dn_p1_n(btn_dn_p1_n),
        .btn_up_p2_n(btn_up_p2_n),
        .btn_dn_p2_n(btn_dn_p2_n),
        .sq_ypos    (sq_ypos),
        .pdl2_ypos  (pdl2_ypos),
        .up_p1      (up_p1),
        .down_p1    (down_p1),
        .up_p2      (up_p2),
        .down_p2    (down_p2),
        .any_press  (any_press)
    );

    int checks = 0;
    int passed = 0;
    int failed = 0;
    int anyCount = 0;

    // Reference model: {dn_p2, up_p2, dn_p1, up_p1}
    logic [3:0] raw;
    logic [3:0] hist[$];
    logic [3:0] acceptM;
    logic [3:0] outM;
    logic       anyM;
    int         edgeNo;
    int         cpuMove;

    function automatic logic [3:0] histAt(int back);
        if (back >= hist.size()) return 4'hF;
        return hist[hist.size() - 1 - back];
    endfunction

    function automatic int decide(int sq, int pdl);
        int bc, pc;
        bc = sq + 8;
        pc = pdl + 48;
        if (bc + 8 < pc) return 1;
        if (bc > pc + 8) return 2;
        return 0;
    endfunction

    task automatic modelReset();
        hist.delete();
        acceptM = 4'hF;
        outM    = 4'hF;
        anyM    = 1'b0;
        edgeNo  = 0;
        cpuMove = 0;
    endtask

    // Accepted level flips once the last DEB synchronised samples all show the new value
    task automatic modelEdge();
        logic [3:0] s;
        logic       v;
        logic       allSame;
        hist.push_back(raw);
        if (hist.size() > 32) void'(hist.pop_front());
        anyM = |(outM & ~acceptM);
        outM = acceptM;
        for (int b = 0; b < 4; b++) begin
            s = histAt(2);
            v = s[b];
            allSame = 1'b1;
            for (int j = 2; j <= DEB + 1; j++) begin
                s = histAt(j);
                if (s[b] != v) allSame = 1'b0;
            end
            if (allSame && v != acceptM[b]) acceptM[b] = v;
        end
        if (edgeNo % REACT == REACT - 1) cpuMove = decide(int'(sq_ypos), int'(pdl2_ypos));
        edgeNo++;
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic checkCount(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkBit("up_p1", up_p1, outM[0]);
        checkBit("down_p1", down_p1, outM[1]);
`ifdef CPU_PLAYER2_EN
        checkBit("up_p2_cpu", up_p2, cpuMove != 1);
        checkBit("down_p2_cpu", down_p2, cpuMove != 2);
`else
        checkBit("up_p2", up_p2, outM[2]);
        checkBit("down_p2", down_p2, outM[3]);
`endif
        checkBit("any_press", any_press, anyM);
    endtask

    task automatic applyStimulus(input logic [3:0] r, input int n);
        raw = r;
        btn_up_p1_n = r[0];
        btn_dn_p1_n = r[1];
        btn_up_p2_n = r[2];
        btn_dn_p2_n = r[3];
        repeat (n) begin
            @(posedge clk_0);
            modelEdge();
            #1;
            if (any_press === 1'b1) anyCount++;
            checkOutput();
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput();
        @(posedge clk_0);
        @(posedge clk_0);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int startAny;
        logic [3:0] r;
        rst = 1'b0;
        raw = 4'hF;
        btn_up_p1_n = 1'b1;
        btn_dn_p1_n = 1'b1;
        btn_up_p2_n = 1'b1;
        btn_dn_p2_n = 1'b1;
        sq_ypos   = 10'd231;
        pdl2_ypos = 10'd191;
        modelReset();
        #2;
        doReset();
        checkBit("reset_up_p1", up_p1, 1'b1);
        checkBit("reset_any", any_press, 1'b0);

        $display("[TB] case 1: single press latency");
        startAny = anyCount;
        applyStimulus(4'b1110, 10);
        checkBit("t1_edge9_up_p1", up_p1, 1'b1);
        applyStimulus(4'b1110, 1);
        checkBit("t1_edge10_up_p1", up_p1, 1'b0);
        checkBit("t1_edge10_any", any_press, 1'b1);
        applyStimulus(4'b1110, 1);
        checkBit("t1_edge11_any", any_press, 1'b0);
        checkCount("t1_pulses", anyCount - startAny, 1);
        applyStimulus(4'hF, 12);
        checkBit("t1_release_up_p1", up_p1, 1'b1);

        $display("[TB] case 2: short glitch rejected");
        startAny = anyCount;
        applyStimulus(4'b0111, 5);
        applyStimulus(4'hF, 15);
        checkBit("t2_down_p2", down_p2, 1'b1);
        checkCount("t2_pulses", anyCount - startAny, 0);

        $display("[TB] case 3: simultaneous press");
        startAny = anyCount;
        applyStimulus(4'b1100, 10);
        checkBit("t3_edge9_up", up_p1, 1'b1);
        applyStimulus(4'b1100, 1);
        checkBit("t3_edge10_up", up_p1, 1'b0);
        checkBit("t3_edge10_dn", down_p1, 1'b0);
        applyStimulus(4'b1100, 6);
        checkCount("t3_pulses", anyCount - startAny, 1);
        applyStimulus(4'hF, 12);

        $display("[TB] case 4: reset mid-debounce");
        doReset();
        applyStimulus(4'b1110, 6);
        doReset();
        checkBit("t4_reset_up_p1", up_p1, 1'b1);
        applyStimulus(4'b1110, 10);
        checkBit("t4_edge9_up_p1", up_p1, 1'b1);
        applyStimulus(4'b1110, 1);
        checkBit("t4_edge10_up_p1", up_p1, 1'b0);
        applyStimulus(4'hF, 12);

`ifdef CPU_PLAYER2_EN
        $display("[TB] case 5: CPU tracking");
        doReset();
        sq_ypos = 10'd100;
        applyStimulus(4'hF, 4);
        checkBit("t5_up", up_p2, 1'b0);
        sq_ypos = 10'd231;
        applyStimulus(4'hF, 4);
        checkBit("t5_hold_up", up_p2, 1'b1);
        checkBit("t5_hold_dn", down_p2, 1'b1);
        sq_ypos = 10'd300;
        applyStimulus(4'hF, 4);
        checkBit("t5_down", down_p2, 1'b0);

        $display("[TB] case 6: P2 buttons ignored by CPU outputs");
        startAny = anyCount;
        applyStimulus(4'b1011, 14);
        checkBit("t6_up_p2", up_p2, 1'b1);
        checkCount("t6_pulses", anyCount - startAny, 1);
        applyStimulus(4'hF, 12);
`endif

        $display("[TB] random activity");
        r = 4'hF;
        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
            end
            if ($urandom_range(0, 7) == 0) sq_ypos = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 7) == 0) pdl2_ypos = 10'($urandom_range(0, 1023));
            applyStimulus(r, 1);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
